// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard/stall controller: FSM states,
// MIPS opcode/funct fields and the default PCSrc codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [4:0] FUNCT_JR_HI = 5'b00100;

  localparam logic [2:0] PCSRC_SEQ = 3'b000;
  localparam logic [2:0] PCSRC_BR  = 3'b001;
  localparam logic [2:0] PCSRC_J   = 3'b010;
  localparam logic [2:0] PCSRC_JR  = 3'b011;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use and jr
// stalls, branch/jump flushes and data-memory freeze, plus stall statistics.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int                 RA_W       = 5,
  parameter int                 PCSRC_W    = 3,
  parameter logic [PCSRC_W-1:0] BR_CODE    = 3'b001,
  parameter int                 LOAD_STALL = 1,
  parameter int                 JR_STALL   = 1,
  parameter int                 CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        id_instr,
  input  logic [PCSRC_W-1:0] id_pcsrc,
  input  logic [PCSRC_W-1:0] ex_pcsrc,
  input  logic               ex_br_taken,
  input  logic               ex_mem_rd,
  input  logic               ex_reg_wr,
  input  logic [RA_W-1:0]    ex_wr_reg,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               if_id_flush,
  output logic               id_ex_flush,
  output logic               pipe_freeze,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [2:0] LOAD_CNT0 = 3'(LOAD_STALL - 1);
  localparam logic [2:0] JR_CNT0   = 3'(JR_STALL - 1);

  state_t          state;
  state_t          ret_state;
  logic [2:0]      cnt;
  logic [2:0]      ret_cnt;

  logic [RA_W-1:0] rs;
  logic [RA_W-1:0] rt;
  logic            is_jr;
  logic            lu;
  logic            jh;
  logic            bt;
  logic            jf;
  logic            mw;
  logic            unused_instr;

  assign rs    = RA_W'(id_instr[25:21]);
  assign rt    = RA_W'(id_instr[20:16]);
  assign is_jr = (id_instr[31:26] == OP_RTYPE) && (id_instr[5:1] == FUNCT_JR_HI);

  assign lu = ex_mem_rd && (ex_wr_reg != '0) && ((ex_wr_reg == rs) || (ex_wr_reg == rt));
  assign jh = is_jr && ex_reg_wr && (ex_wr_reg != '0) && (ex_wr_reg == rs);
  assign bt = (ex_pcsrc == BR_CODE) && ex_br_taken;
  assign jf = id_pcsrc > BR_CODE;
  assign mw = mem_req && !mem_ready;

  assign unused_instr = ^{id_instr[15:6], id_instr[0]};

  // State owns multi-cycle bubbles; a memory wait parks the current
  // state/count and the first non-wait cycle resumes from the saved copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      cnt       <= '0;
      ret_state <= ST_RUN;
      ret_cnt   <= '0;
    end else if (mw) begin
      if (state != ST_FREEZE) begin
        ret_state <= state;
        ret_cnt   <= cnt;
      end
      state <= ST_FREEZE;
    end else begin
      case (state)
        ST_RUN: begin
          if (bt) begin
            state <= ST_RUN;
          end else if (lu) begin
            if (LOAD_STALL > 1) begin
              state <= ST_STALL;
              cnt   <= LOAD_CNT0;
            end
          end else if (jh) begin
            if (JR_STALL > 1) begin
              state <= ST_STALL;
              cnt   <= JR_CNT0;
            end
          end
        end
        ST_STALL: begin
          if (bt || (cnt <= 3'd1)) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_FREEZE: begin
          // The restore cycle itself plays out one step of the saved state.
          if ((ret_state == ST_STALL) && (ret_cnt > 3'd1)) begin
            state <= ST_STALL;
            cnt   <= ret_cnt - 3'd1;
          end else begin
            state <= ST_RUN;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_freeze = 1'b0;
    if (reset) begin
      if (mw) begin
        pipe_freeze = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end else begin
        case (state)
          ST_RUN: begin
            if (bt) begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end else if (lu || jh) begin
              pc_write    = 1'b0;
              if_id_write = 1'b0;
              id_ex_flush = 1'b1;
            end else if (jf) begin
              if_id_flush = 1'b1;
            end
          end
          ST_STALL: begin
            if (bt) begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end else begin
              pc_write    = 1'b0;
              if_id_write = 1'b0;
              id_ex_flush = 1'b1;
            end
          end
          ST_FREEZE: begin
            if (ret_state == ST_STALL) begin
              pc_write    = 1'b0;
              if_id_write = 1'b0;
              id_ex_flush = 1'b1;
            end
          end
          default: begin
            pc_write = 1'b1;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (!pc_write),
    .clr  (1'b0),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances (LOAD_STALL=2 and a
// LOAD_STALL=3 / 3-bit-counter variant) share one set of inputs.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] id_instr;
  logic [2:0]  id_pcsrc;
  logic [2:0]  ex_pcsrc;
  logic        ex_br_taken;
  logic        ex_mem_rd;
  logic        ex_reg_wr;
  logic [4:0]  ex_wr_reg;
  logic        mem_req;
  logic        mem_ready;

  logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_flush, a_pipe_freeze;
  logic [15:0] a_cnt;
  logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_pipe_freeze;
  logic [2:0]  b_cnt;
  logic [4:0]  a_outs;
  logic [4:0]  b_outs;

  int n_chk  = 0;
  int n_fail = 0;

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze}
  localparam logic [4:0] IDLE  = 5'b11000;
  localparam logic [4:0] BUBL  = 5'b00010;
  localparam logic [4:0] BRFL  = 5'b11110;
  localparam logic [4:0] JMPFL = 5'b11100;
  localparam logic [4:0] FRZ   = 5'b00001;

  assign a_outs = {a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_flush, a_pipe_freeze};
  assign b_outs = {b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_pipe_freeze};

  pipe_hazard_ctrl #(.LOAD_STALL(2), .JR_STALL(1)) u_a (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_pcsrc(id_pcsrc),
    .ex_pcsrc(ex_pcsrc), .ex_br_taken(ex_br_taken), .ex_mem_rd(ex_mem_rd),
    .ex_reg_wr(ex_reg_wr), .ex_wr_reg(ex_wr_reg), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_write(a_pc_write), .if_id_write(a_if_id_write),
    .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush),
    .pipe_freeze(a_pipe_freeze), .stall_cnt(a_cnt)
  );

  pipe_hazard_ctrl #(.LOAD_STALL(3), .JR_STALL(1), .CNT_W(3)) u_b (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_pcsrc(id_pcsrc),
    .ex_pcsrc(ex_pcsrc), .ex_br_taken(ex_br_taken), .ex_mem_rd(ex_mem_rd),
    .ex_reg_wr(ex_reg_wr), .ex_wr_reg(ex_wr_reg), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_write(b_pc_write), .if_id_write(b_if_id_write),
    .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
    .pipe_freeze(b_pipe_freeze), .stall_cnt(b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [2:0]  idpc;
    logic [2:0]  expc;
    logic        br;
    logic        mrd;
    logic        rwr;
    logic [4:0]  wr;
    logic        req;
    logic        rdy;
    logic [4:0]  exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [2:0] idpc, input logic [2:0] expc,
                       input logic br, input logic mrd, input logic rwr, input logic [4:0] wr,
                       input logic req, input logic rdy);
    id_instr    = instr;
    id_pcsrc    = idpc;
    ex_pcsrc    = expc;
    ex_br_taken = br;
    ex_mem_rd   = mrd;
    ex_reg_wr   = rwr;
    ex_wr_reg   = wr;
    mem_req     = req;
    mem_ready   = rdy;
  endtask

  task automatic idle();
    drive(32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    idle();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic add_vec(input string nm, input logic [31:0] instr, input logic [2:0] idpc,
                         input logic [2:0] expc, input logic br, input logic mrd,
                         input logic rwr, input logic [4:0] wr, input logic req,
                         input logic rdy, input logic [4:0] exp);
    vec_t v;
    v.name = nm; v.instr = instr; v.idpc = idpc; v.expc = expc; v.br = br;
    v.mrd = mrd; v.rwr = rwr; v.wr = wr; v.req = req; v.rdy = rdy; v.exp = exp;
    vq.push_back(v);
  endtask

  logic [31:0] add_9_8_1, add_9_2_8, add_9_0_1, add_9_31_1, jr_31, jalr_5;

  initial begin
    reset = 1'b0;
    idle();
    add_9_8_1  = rtype(5'd8, 5'd1, 5'd9, 6'h20);
    add_9_2_8  = rtype(5'd2, 5'd8, 5'd9, 6'h20);
    add_9_0_1  = rtype(5'd0, 5'd1, 5'd9, 6'h20);
    add_9_31_1 = rtype(5'd31, 5'd1, 5'd9, 6'h20);
    jr_31      = rtype(5'd31, 5'd0, 5'd0, 6'h08);
    jalr_5     = rtype(5'd5, 5'd0, 5'd31, 6'h09);

    add_vec("idle",          32'd0,      0, 0, 0, 0, 0, 5'd0,  0, 0, IDLE);
    add_vec("lu_rs",         add_9_8_1,  0, 0, 0, 1, 1, 5'd8,  0, 0, BUBL);
    add_vec("lu_rt",         add_9_2_8,  0, 0, 0, 1, 1, 5'd8,  0, 0, BUBL);
    add_vec("lu_r0",         add_9_0_1,  0, 0, 0, 1, 1, 5'd0,  0, 0, IDLE);
    add_vec("alu_fwd",       add_9_8_1,  0, 0, 0, 0, 1, 5'd8,  0, 0, IDLE);
    add_vec("jh_jr31",       jr_31,      3, 0, 0, 0, 1, 5'd31, 0, 0, BUBL);
    add_vec("jr31_nowr",     jr_31,      3, 0, 0, 0, 0, 5'd31, 0, 0, JMPFL);
    add_vec("jr31_load",     jr_31,      3, 0, 0, 1, 1, 5'd31, 0, 0, BUBL);
    add_vec("nonjr_alu",     add_9_31_1, 0, 0, 0, 0, 1, 5'd31, 0, 0, IDLE);
    add_vec("jh_jalr",       jalr_5,     3, 0, 0, 0, 1, 5'd5,  0, 0, BUBL);
    add_vec("br_taken",      32'd0,      0, 1, 1, 0, 0, 5'd0,  0, 0, BRFL);
    add_vec("br_not_taken",  32'd0,      0, 1, 0, 0, 0, 5'd0,  0, 0, IDLE);
    add_vec("br_over_lu",    add_9_8_1,  0, 1, 1, 1, 1, 5'd8,  0, 0, BRFL);
    add_vec("jump_flush",    32'd0,      2, 0, 0, 0, 0, 5'd0,  0, 0, JMPFL);
    add_vec("lu_over_jump",  add_9_8_1,  2, 0, 0, 1, 1, 5'd8,  0, 0, BUBL);
    add_vec("br_in_id",      32'd0,      1, 0, 0, 0, 0, 5'd0,  0, 0, IDLE);
    add_vec("mem_wait",      32'd0,      0, 0, 0, 0, 0, 5'd0,  1, 0, FRZ);
    add_vec("mw_over_all",   add_9_8_1,  2, 1, 1, 1, 1, 5'd8,  1, 0, FRZ);
    add_vec("mem_ready",     32'd0,      0, 0, 0, 0, 0, 5'd0,  1, 1, IDLE);
    add_vec("jump_in_ex",    32'd0,      0, 2, 1, 0, 0, 5'd0,  0, 0, IDLE);

    hard_reset();
    #1;
    chk("reset_outs_a", a_outs, IDLE);
    chk("reset_cnt_a", a_cnt, 0);
    chk("reset_cnt_b", b_cnt, 0);

    foreach (vq[i]) begin
      hard_reset();
      drive(vq[i].instr, vq[i].idpc, vq[i].expc, vq[i].br, vq[i].mrd, vq[i].rwr,
            vq[i].wr, vq[i].req, vq[i].rdy);
      #1;
      chk({vq[i].name, "_a"}, a_outs, vq[i].exp);
      chk({vq[i].name, "_b"}, b_outs, vq[i].exp);
    end

    // Load-use: 2 bubbles on A, 3 on B
    hard_reset();
    drive(add_9_8_1, 0, 0, 0, 1, 1, 5'd8, 0, 0);
    #1; chk("lu_c1_a", a_outs, BUBL); chk("lu_c1_b", b_outs, BUBL);
    @(negedge clk); #1; chk("lu_c2_a", a_outs, BUBL);
    @(negedge clk); idle(); #1;
    chk("lu_c3_a", a_outs, IDLE); chk("lu_c3_b", b_outs, BUBL); chk("lu_cnt_a", a_cnt, 2);
    @(negedge clk); #1; chk("lu_c4_b", b_outs, IDLE); chk("lu_cnt_b", b_cnt, 3);

    // Branch taken in STALL with one bubble left
    hard_reset();
    drive(add_9_8_1, 0, 0, 0, 1, 1, 5'd8, 0, 0); #1;
    @(negedge clk); idle(); #1; chk("bt1_c2_b", b_outs, BUBL);
    @(negedge clk); drive(32'd0, 0, 1, 1, 0, 0, 5'd0, 0, 0); #1; chk("bt1_c3_b", b_outs, BRFL);
    @(negedge clk); idle(); #1; chk("bt1_c4_b", b_outs, IDLE); chk("bt1_cnt_b", b_cnt, 2);

    // Branch taken in STALL with two bubbles left aborts the stall
    hard_reset();
    drive(add_9_8_1, 0, 0, 0, 1, 1, 5'd8, 0, 0); #1;
    @(negedge clk); drive(32'd0, 0, 1, 1, 0, 0, 5'd0, 0, 0); #1; chk("bt2_c2_b", b_outs, BRFL);
    @(negedge clk); idle(); #1; chk("bt2_c3_b", b_outs, IDLE);

    // jr hazard: one bubble, then the jump proceeds
    hard_reset();
    drive(jr_31, 3, 0, 0, 0, 1, 5'd31, 0, 0); #1; chk("jh_c1_a", a_outs, BUBL);
    @(negedge clk); drive(jr_31, 3, 0, 0, 0, 0, 5'd0, 0, 0); #1;
    chk("jh_c2_a", a_outs, JMPFL); chk("jh_cnt_a", a_cnt, 1);

    // Memory wait during a LOAD_STALL=3 stall at cnt=2
    hard_reset();
    drive(add_9_8_1, 0, 0, 0, 1, 1, 5'd8, 0, 0); #1; chk("fz_c1_b", b_outs, BUBL);
    @(negedge clk); drive(32'd0, 0, 0, 0, 0, 0, 5'd0, 1, 0); #1;
    chk("fz_c2_b", b_outs, FRZ); chk("fz_c2_a", a_outs, FRZ);
    @(negedge clk); #1; chk("fz_c3_b", b_outs, FRZ);
    @(negedge clk); #1; chk("fz_c4_b", b_outs, FRZ);
    @(negedge clk); drive(32'd0, 0, 0, 0, 0, 0, 5'd0, 1, 1); #1;
    chk("fz_c5_b", b_outs, BUBL); chk("fz_c5_a", a_outs, BUBL);
    @(negedge clk); idle(); #1; chk("fz_c6_b", b_outs, BUBL); chk("fz_c6_a", a_outs, IDLE);
    @(negedge clk); #1; chk("fz_c7_b", b_outs, IDLE);
    chk("fz_cnt_b", b_cnt, 6); chk("fz_cnt_a", a_cnt, 5);

    // Counter saturation on the 3-bit instance
    drive(32'd0, 0, 0, 0, 0, 0, 5'd0, 1, 0);
    @(negedge clk); @(negedge clk); #1;
    chk("sat_cnt_b", b_cnt, 7); chk("sat_cnt_a", a_cnt, 7);
    @(negedge clk); #1;
    chk("sat_hold_b", b_cnt, 7); chk("sat_cnt_a2", a_cnt, 8);

    // Asynchronous reset while frozen
    #2; reset = 1'b0; #1;
    chk("rst_fz_outs_b", b_outs, IDLE); chk("rst_fz_outs_a", a_outs, IDLE);
    chk("rst_fz_cnt_b", b_cnt, 0); chk("rst_fz_cnt_a", a_cnt, 0);
    idle();
    @(negedge clk); reset = 1'b1; #1; chk("rst_rel_outs_b", b_outs, IDLE);
    @(negedge clk); #1; chk("rst_rel_cnt_b", b_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and stall controller for the 5-stage MIPS pipeline. It sits between the IF/ID, ID/EX and EX/MEM stage registers and the PC. It generates PC/stage-register write enables and flushes for several cases:
- load-use hazards, with a configurable multi-cycle load latency;
- jr/jalr register hazards;
- taken branches and jumps;
- data-memory wait states.

A registered FSM owns the multi-cycle stalls and the memory freeze. A saturating counter reports total stall cycles.

## Interface
Parameters:
- RA_W, 5, register-address width
- PCSRC_W, 3, width of PCSrc codes
- BR_CODE, 3'b001, PCSrc value meaning conditional branch; any larger value is a jump (j/jal/jr)
- LOAD_STALL, 1, bubbles inserted per load-use hazard (1..7)
- JR_STALL, 1, bubbles inserted per jr/jalr hazard (1..7)
- CNT_W, 16, stall-statistics counter width

Ports (clk/reset: one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_instr  in  32  instruction in IF/ID
- id_pcsrc  in  PCSRC_W  PCSrc decoded in ID
- ex_pcsrc  in  PCSRC_W  PCSrc held in ID/EX
- ex_br_taken  in  1  branch condition (ALUOut[0]) in EX
- ex_mem_rd  in  1  EX instruction is a load
- ex_reg_wr  in  1  EX instruction writes a register
- ex_wr_reg  in  RA_W  EX destination register (Rt for loads, Rd otherwise)
- mem_req  in  1  MEM stage access in progress
- mem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID update enable
- if_id_flush  out  1  IF/ID cleared to nop
- id_ex_flush  out  1  ID/EX cleared to bubble
- pipe_freeze  out  1  ID/EX, EX/MEM, MEM/WB hold
- stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0

## Operation
- Definitions: rs=id_instr[25:21], rt=id_instr[20:16]. is_jr = opcode 0 and funct[5:1]==5'b00100.
- Load-use hazard (LU): ex_mem_rd, ex_wr_reg!=0, and ex_wr_reg equals rs or rt.
- JR hazard (JH): is_jr, ex_reg_wr, ex_wr_reg!=0, and ex_wr_reg==rs.
- Branch flush (BT): ex_pcsrc==BR_CODE and ex_br_taken.
- Jump flush (JF): id_pcsrc>BR_CODE.
- MEM wait (MW): mem_req and !mem_ready.
- FSM states: RUN, STALL, FREEZE. Registers: cnt (3 bit), ret_state, ret_cnt.
- RUN:
  - BT: if_id_flush=1, id_ex_flush=1.
  - Else LU: pc_write=0, if_id_write=0, id_ex_flush=1. If LOAD_STALL>1, go to STALL with cnt=LOAD_STALL-1.
  - Else JH: same outputs, using JR_STALL.
  - JF asserts if_id_flush unless LU/JH is active; a stall takes priority and the jump re-decodes.
- STALL: pc_write=0, if_id_write=0, id_ex_flush=1. cnt decrements; at cnt==1 go to RUN.
  - BT in STALL aborts to RUN with both flushes.
- Priority: MW > BT > LU > JH > JF.
- MW in any state:
  - pipe_freeze=1, pc_write=0, if_id_write=0; all flushes 0.
  - Save state/cnt into ret_state/ret_cnt and enter FREEZE; cnt does not decrement.
- FREEZE:
  - Hold while MW.
  - On mem_ready, restore ret_state/ret_cnt the next cycle. Hazard inputs are evaluated only after restore.
- stall_cnt increments each cycle with pc_write=0, saturating at all-ones.

## Timing
- Reset values: state=RUN, cnt=0, ret_*=RUN/0, stall_cnt=0. With idle inputs: pc_write=1, if_id_write=1, flushes=0, pipe_freeze=0.
- All stall/flush outputs are combinational from state and inputs (same-cycle). State updates on the rising clk.
- LU bubbles: exactly LOAD_STALL cycles from the detection cycle. JH bubbles: exactly JR_STALL cycles.
- FREEZE adds exactly the number of MW cycles. Total stall = bubbles + wait cycles.
- Reset asserted mid-STALL/FREEZE returns to RUN immediately (asynchronous). stall_cnt clears.

## Structure
- hazard_pkg holds:
  - state encoding (RUN=2'd0, STALL=2'd1, FREEZE=2'd2);
  - OP_RTYPE=6'b000000 and FUNCT_JR_HI=5'b00100;
  - default PCSrc codes.
- One sub-module, sat_counter (parameter W; inc, clr), for stall_cnt. The FSM and detection logic stay in pipe_hazard_ctrl.

## Test plan
- LOAD_STALL=2: lw $8 in EX, id_instr add $9,$8,$1:
  - pc_write=0 and id_ex_flush=1 for 2 cycles, then pc_write=1;
  - stall_cnt=2.
- Load with ex_wr_reg=0 matching rs=0 -> no stall; pc_write stays 1.
- Branch taken during STALL (cnt=1 remaining):
  - if_id_flush=1 and id_ex_flush=1 in the same cycle;
  - next cycle state=RUN, pc_write=1.
- jr $31 in ID with ex_reg_wr=1, ex_wr_reg=31, JR_STALL=1 -> one bubble. Same case with ex_reg_wr=0 -> none.
- mem_req=1, mem_ready=0 for 3 cycles during a LOAD_STALL=3 stall at cnt=2:
  - pipe_freeze=1 for 3 cycles;
  - afterwards 2 more bubble cycles;
  - stall_cnt=6 (1 detect + 3 freeze + 2).
- Assert reset mid-FREEZE -> outputs at reset values immediately; stall_cnt=0.
